multipath_channel_n: RTL and testbench
======================================

Name: multipath_channel_n

Overview:
- Parametrised successor to the single-echo multipath channel model.
- Takes one signed transmitter symbol per `multi_start` rising edge and sums NTAPS delayed, attenuated copies of the symbol history.
- Optionally adds LFSR pseudo-noise and saturates the result to OUT_W.
- Sits between the transmitter symbol output and the receiver front end in the channel-model chain.

Parameters:
- SYM_W, 2: signed width of the input symbol (trans_out).
- OUT_W, 14: signed width of multi_out.
- DEPTH, 16: symbol-history depth; power of 2, at least 2.
- NTAPS, 3: number of paths, including the direct path.
- SCALE, 8: left shift applied to a symbol before attenuation; +1 maps to 256.
- TAP_DELAY, {4'd5,4'd2,4'd0}: packed 4-bit per-tap delays in symbols; tap0 is the LSB field; each value must be < DEPTH.
- TAP_SHIFT, {4'd3,4'd1,4'd0}: packed 4-bit per-tap arithmetic right-shift attenuation.
- NOISE_SHIFT, 2: arithmetic right shift applied to the signed 8-bit LFSR value before it is added.

Ports:
- clk, in, 1: single clock, rising edge.
- reset, in, 1: asynchronous, active-low reset.
- multi_start, in, 1: symbol strobe; a new symbol is accepted on its rising edge.
- trans_out, in, SYM_W: signed symbol, sampled on the cycle the rising edge is detected.
- noise_en, in, 1: 1 = add noise; 0 = noise term forced to 0.
- multi_out, out, OUT_W: signed channel output, held between updates.
- multi_valid, out, 1: one-cycle pulse when multi_out updates.
- busy, out, 1: high from symbol accept until multi_valid.
- overrun, out, 1: sticky; set when a start edge arrives while busy.

Behaviour:
- Reset (reset=0, asynchronous):
  - multi_out=0, multi_valid=0, busy=0, overrun=0.
  - All history entries = 0; wr_ptr = 0; state = IDLE.
  - LFSR = 8'hA5; start-edge register = 0.
  - A reset mid-computation aborts it; no multi_valid is produced.
- Start detection: registered copy of multi_start; edge = multi_start & ~prev. Level-held strobes count once.
- State machine:
  - IDLE: on edge, write trans_out to hist[wr_ptr], clear acc, tap index k=0, busy=1, go to ACCUM.
  - ACCUM: one tap per cycle.
    - rd = (wr_ptr - TAP_DELAY[k]) mod DEPTH.
    - acc += (sext(hist[rd]) <<< SCALE) >>> TAP_SHIFT[k].
    - After k = NTAPS-1, go to NOISE.
  - NOISE: acc += noise_en ? ($signed(lfsr) >>> NOISE_SHIFT) : 0. Advance the LFSR once (advances even when noise_en=0). Go to OUT.
  - OUT:
    - multi_out = sat(acc); multi_valid = 1 for this cycle only.
    - wr_ptr = wr_ptr + 1, wrapping DEPTH-1 -> 0.
    - busy = 0; go to IDLE.
- Latency: edge-detect cycle, then NTAPS+2 cycles to multi_valid. Default: multi_valid on the 6th clock after the cycle in which multi_start is first sampled high.
- Arithmetic:
  - Accumulator width ACC_W = OUT_W+4, signed.
  - Shifts are arithmetic, so negative values floor.
  - Saturation clamps to [-2^(OUT_W-1), 2^(OUT_W-1)-1].
- History: entries never written read as 0, so early outputs contain only the direct path. History wraps modulo DEPTH with no "full" condition; the oldest entry is overwritten.
- Start edge while busy: the symbol is dropped, overrun=1 (sticky until reset), the current computation is unaffected.
- Start edge in the same cycle as OUT: treated as busy, so it is dropped and overrun is set.
- LFSR polynomial: x^8+x^6+x^5+x^4+1, Fibonacci form, shifting left, feedback into bit 0.

Decomposition:
- Shared package channel_pkg:
  - state enum (IDLE, ACCUM, NOISE, OUT).
  - LFSR seed 8'hA5 and tap mask.
  - function sat_to_width.
  - function to extract the 4-bit field k from TAP_DELAY / TAP_SHIFT.
- Sub-module channel_lfsr:
  - Ports: clk, reset, adv, lfsr[7:0].
  - Reused by later channel blocks.
- History RAM, pointer and FSM stay in the top module.

Test Plan:
- Reset then first symbol: reset low for 30 ps, trans_out=+1, noise_en=0, one start pulse -> multi_out=256, multi_valid pulses exactly once 6 clocks after the start sample, overrun=0.
- Alternating symbols: +1, -1, +1, ... with noise_en=0, 100 ps strobes separated by 10 ps low -> outputs 256, -256, 384, -384, 384, -352, 352, -352 (steady state ±352).
- Constant +1 for 8 symbols, noise_en=0 -> outputs 256, 256, 384, 384, 384, 416, 416, 416. Extend the run past 16 symbols -> still 416 across the wr_ptr wrap.
- Saturation: override SCALE=9, OUT_W=10, constant +1 -> the steady-state sum of 832 clamps to 511. Constant -1 -> -512.
- Overrun and reset mid-op:
  - Start edge issued 2 cycles after a prior edge -> second symbol dropped, overrun=1, first result correct.
  - Reset asserted during ACCUM -> no multi_valid, all outputs 0, next symbol behaves as the first-symbol case.
- Noise:
  - noise_en=1, trans_out=+1 first symbol from reset -> multi_out = 256 + ($signed(8'hA5)>>>2) = 256 - 23 = 233.
  - Same case with noise_en=0 -> 256.

Source files
------------

// File: rtl/channel_pkg.sv
// channel_pkg: shared types, LFSR constants and helpers for the channel-model blocks.
package channel_pkg;

    typedef enum logic [1:0] {IDLE, ACCUM, NOISE, OUT} state_t;

    localparam logic [7:0] LFSR_SEED = 8'hA5;
    // x^8+x^6+x^5+x^4+1 feeds back from bits 7,5,4,3
    localparam logic [7:0] LFSR_TAPS = 8'hB8;

    function automatic logic signed [31:0] sat_to_width(input logic signed [31:0] v, input int unsigned w);
        logic signed [31:0] hi;
        logic signed [31:0] lo;
        hi = (32'sd1 <<< (w - 1)) - 32'sd1;
        lo = -hi - 32'sd1;
        return v > hi ? hi : v < lo ? lo : v;
    endfunction

    function automatic logic [3:0] tap_field(input logic [63:0] packed_v, input int k);
        return packed_v[k*4 +: 4];
    endfunction

endpackage

// File: rtl/multipath_channel_n_if.sv
// multipath_channel_n_if: symbol strobe in, channel output and status back.
interface multipath_channel_n_if #(
    parameter int SYM_W = 2,
    parameter int OUT_W = 14
);
    logic                    multi_start;
    logic signed [SYM_W-1:0] trans_out;
    logic                    noise_en;
    logic signed [OUT_W-1:0] multi_out;
    logic                    multi_valid;
    logic                    busy;
    logic                    overrun;

    modport master (
        output multi_start, trans_out, noise_en,
        input  multi_out, multi_valid, busy, overrun
    );

    modport slave (
        input  multi_start, trans_out, noise_en,
        output multi_out, multi_valid, busy, overrun
    );
endinterface

// File: rtl/channel_lfsr.sv
// channel_lfsr: 8-bit Fibonacci pseudo-noise source, shifts left once per adv.
module channel_lfsr
    import channel_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic       adv,
    output logic [7:0] lfsr
);
    logic [7:0] lfsr_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            lfsr_q <= LFSR_SEED;
        else if (adv)
            lfsr_q <= {lfsr_q[6:0], ^(lfsr_q & LFSR_TAPS)};
    end

    assign lfsr = lfsr_q;
endmodule

// File: rtl/multipath_channel_n.sv
// multipath_channel_n: sums NTAPS delayed, attenuated copies of the symbol history,
// adds optional pseudo-noise and saturates to OUT_W; one tap per cycle.
module multipath_channel_n
    import channel_pkg::*;
#(
    parameter int SYM_W       = 2,
    parameter int OUT_W       = 14,
    parameter int DEPTH       = 16,
    parameter int NTAPS       = 3,
    parameter int SCALE       = 8,
    parameter logic [4*NTAPS-1:0] TAP_DELAY = {4'd5, 4'd2, 4'd0},
    parameter logic [4*NTAPS-1:0] TAP_SHIFT = {4'd3, 4'd1, 4'd0},
    parameter int NOISE_SHIFT = 2
) (
    input logic clk,
    input logic reset,
    multipath_channel_n_if.slave ch
);
    localparam int ACC_W = OUT_W + 4;
    localparam int PW    = $clog2(DEPTH);
    localparam int KW    = $clog2(NTAPS + 1);

    state_t                  state_q;
    logic [PW-1:0]           wr_ptr_q;
    logic [KW-1:0]           k_q;
    logic signed [ACC_W-1:0] acc_q;
    logic signed [SYM_W-1:0] hist_q [DEPTH];
    logic signed [OUT_W-1:0] out_q;
    logic                    valid_q;
    logic                    busy_q;
    logic                    overrun_q;
    logic                    start_q;
    logic                    edge_d;
    logic [PW-1:0]           rd_d;
    logic signed [ACC_W-1:0] tap_d;
    logic signed [ACC_W-1:0] noise_d;
    logic                    adv;
    logic [7:0]              lfsr;

    channel_lfsr u_lfsr (
        .clk   (clk),
        .reset (reset),
        .adv   (adv),
        .lfsr  (lfsr)
    );

    always_comb begin
        edge_d  = ch.multi_start & ~start_q;
        rd_d    = wr_ptr_q - PW'(tap_field(64'(TAP_DELAY), int'(k_q)));
        tap_d   = (ACC_W'(hist_q[rd_d]) <<< SCALE) >>> tap_field(64'(TAP_SHIFT), int'(k_q));
        noise_d = ch.noise_en ? ACC_W'($signed(lfsr) >>> NOISE_SHIFT) : '0;
        adv     = state_q == NOISE;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= IDLE;
            wr_ptr_q  <= '0;
            k_q       <= '0;
            acc_q     <= '0;
            out_q     <= '0;
            valid_q   <= 1'b0;
            busy_q    <= 1'b0;
            overrun_q <= 1'b0;
            start_q   <= 1'b0;
            for (int i = 0; i < DEPTH; i++)
                hist_q[i] <= '0;
        end else begin
            start_q <= ch.multi_start;
            valid_q <= 1'b0;
            // any edge outside IDLE (including the OUT cycle) is a dropped symbol
            if (edge_d && state_q != IDLE)
                overrun_q <= 1'b1;
            case (state_q)
                IDLE: if (edge_d) begin
                    hist_q[wr_ptr_q] <= ch.trans_out;
                    acc_q            <= '0;
                    k_q              <= '0;
                    busy_q           <= 1'b1;
                    state_q          <= ACCUM;
                end
                ACCUM: begin
                    acc_q <= acc_q + tap_d;
                    k_q   <= k_q + 1'b1;
                    if (k_q == KW'(NTAPS - 1))
                        state_q <= NOISE;
                end
                NOISE: begin
                    acc_q   <= acc_q + noise_d;
                    state_q <= OUT;
                end
                OUT: begin
                    out_q    <= OUT_W'(sat_to_width(32'(acc_q), OUT_W));
                    valid_q  <= 1'b1;
                    wr_ptr_q <= wr_ptr_q + 1'b1;
                    busy_q   <= 1'b0;
                    state_q  <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign ch.multi_out   = out_q;
    assign ch.multi_valid = valid_q;
    assign ch.busy        = busy_q;
    assign ch.overrun     = overrun_q;
endmodule

// File: tb/tb_multipath_channel_n.sv
// tb_multipath_channel_n: random and directed symbol streams against an arithmetic channel model;
// a second instance with SCALE=9, OUT_W=10 shares the stimulus to exercise saturation.
`timescale 1ps/1ps
module tb_multipath_channel_n;
    logic clk = 1'b0;
    logic reset = 1'b0;
    logic ms = 1'b0;
    logic signed [1:0] tx = '0;
    logic ne = 1'b0;
    int n_cmp = 0;
    int n_fail = 0;

    int syms[$];
    int lfsr_m;
    int exp_main, exp_sat;

    always #5 clk = ~clk;

    multipath_channel_n_if #(.SYM_W(2), .OUT_W(14)) ch ();
    multipath_channel_n_if #(.SYM_W(2), .OUT_W(10)) cs ();

    assign ch.multi_start = ms;
    assign ch.trans_out   = tx;
    assign ch.noise_en    = ne;
    assign cs.multi_start = ms;
    assign cs.trans_out   = tx;
    assign cs.noise_en    = ne;

    multipath_channel_n u_dut (.clk(clk), .reset(reset), .ch(ch.slave));
    multipath_channel_n #(.OUT_W(10), .SCALE(9)) u_sat (.clk(clk), .reset(reset), .ch(cs.slave));

    function automatic int fdiv(int a, int b);
        return a >= 0 ? a / b : -((-a + b - 1) / b);
    endfunction

    // output = sum over paths of symbol(n-delay)*2^scale/2^atten (floored), plus noise, clamped
    function automatic int model(int scale, int outw, bit noise);
        int d[3] = '{0, 2, 5};
        int s[3] = '{0, 1, 3};
        int acc = 0;
        int hi = (1 << (outw - 1)) - 1;
        int n = syms.size();
        for (int k = 0; k < 3; k++)
            if (n - 1 - d[k] >= 0)
                acc += fdiv(syms[n - 1 - d[k]] * (1 << scale), 1 << s[k]);
        if (noise)
            acc += fdiv(lfsr_m > 127 ? lfsr_m - 256 : lfsr_m, 4);
        return acc > hi ? hi : acc < -hi - 1 ? -hi - 1 : acc;
    endfunction

    function automatic int lfsr_next(int l);
        int fb = ((l >> 7) ^ (l >> 5) ^ (l >> 4) ^ (l >> 3)) & 1;
        return ((l << 1) & 255) | fb;
    endfunction

    task automatic accept(input int sym, input bit noise);
        syms.push_back(sym);
        exp_main = model(8, 14, noise);
        exp_sat  = model(9, 10, noise);
        lfsr_m   = lfsr_next(lfsr_m);
    endtask

    task automatic do_reset();
        ms = 1'b0;
        ne = 1'b0;
        reset = 1'b0;
        #30;
        @(negedge clk);
        reset = 1'b1;
        syms.delete();
        lfsr_m = 8'hA5;
    endtask

    // strobe held 10 cycles then low 1 cycle; cyc is the negedge index at which valid was seen
    task automatic send(input int sym, input bit noise, output int cyc, output int nv,
                        output int om, output int os, output int bsy);
        @(negedge clk);
        ms = 1'b1;
        tx = 2'(sym);
        ne = noise;
        cyc = 0; nv = 0; om = 0; os = 0; bsy = 0;
        for (int c = 1; c <= 10; c++) begin
            @(negedge clk);
            if (c == 1) bsy = int'(ch.busy);
            if (ch.multi_valid) begin
                nv++;
                cyc = c;
                om = int'(ch.multi_out);
                os = int'(cs.multi_out);
            end
        end
        ms = 1'b0;
        accept(sym, noise);
    endtask

    task automatic test_reset();
        do_reset();
        #1;
        if (ch.multi_out !== 14'sd0) begin $display("FAIL reset_out got %0d want 0", ch.multi_out); n_fail++; end
        n_cmp++;
        if (ch.multi_valid !== 1'b0) begin $display("FAIL reset_valid got %b want 0", ch.multi_valid); n_fail++; end
        n_cmp++;
        if (ch.busy !== 1'b0) begin $display("FAIL reset_busy got %b want 0", ch.busy); n_fail++; end
        n_cmp++;
        if (ch.overrun !== 1'b0) begin $display("FAIL reset_overrun got %b want 0", ch.overrun); n_fail++; end
        n_cmp++;
    endtask

    task automatic test_first_symbol();
        int cyc, nv, om, os, bsy;
        do_reset();
        send(1, 1'b0, cyc, nv, om, os, bsy);
        if (om !== exp_main) begin $display("FAIL first_out got %0d want %0d", om, exp_main); n_fail++; end
        n_cmp++;
        if (nv !== 1) begin $display("FAIL first_valid_count got %0d want 1", nv); n_fail++; end
        n_cmp++;
        if (cyc !== 6) begin $display("FAIL first_latency got %0d want 6", cyc); n_fail++; end
        n_cmp++;
        if (bsy !== 1) begin $display("FAIL first_busy got %0d want 1", bsy); n_fail++; end
        n_cmp++;
        if (ch.overrun !== 1'b0) begin $display("FAIL first_overrun got %b want 0", ch.overrun); n_fail++; end
        n_cmp++;
        if (ch.multi_out !== 14'(exp_main)) begin $display("FAIL first_hold got %0d want %0d", ch.multi_out, exp_main); n_fail++; end
        n_cmp++;
    endtask

    task automatic test_stream(input string name, input int mode, input int count);
        int cyc, nv, om, os, bsy, sym;
        bit noise;
        do_reset();
        for (int i = 0; i < count; i++) begin
            sym   = mode == 0 ? (i % 2 == 0 ? 1 : -1) : mode == 1 ? 1 : mode == 2 ? -1 : int'($urandom_range(0, 3)) - 2;
            noise = mode == 3 ? 1'($urandom_range(0, 1)) : 1'b0;
            send(sym, noise, cyc, nv, om, os, bsy);
            if (nv !== 1 || om !== exp_main) begin
                $display("FAIL %s_out[%0d] got %0d (valids %0d) want %0d", name, i, om, nv, exp_main); n_fail++;
            end
            n_cmp++;
            if (os !== exp_sat) begin $display("FAIL %s_sat[%0d] got %0d want %0d", name, i, os, exp_sat); n_fail++; end
            n_cmp++;
        end
    endtask

    task automatic test_overrun();
        int nv = 0, om = 0, cyc, os, bsy;
        do_reset();
        @(negedge clk); ms = 1'b1; tx = 2'sd1;
        @(negedge clk); ms = 1'b0;
        @(negedge clk); ms = 1'b1; tx = -2'sd1;
        for (int c = 3; c <= 12; c++) begin
            @(negedge clk);
            if (c == 5) ms = 1'b0;
            if (ch.multi_valid) begin nv++; om = int'(ch.multi_out); end
        end
        accept(1, 1'b0);
        if (nv !== 1 || om !== exp_main) begin $display("FAIL overrun_first got %0d (valids %0d) want %0d", om, nv, exp_main); n_fail++; end
        n_cmp++;
        if (ch.overrun !== 1'b1) begin $display("FAIL overrun_flag got %b want 1", ch.overrun); n_fail++; end
        n_cmp++;
        send(1, 1'b0, cyc, nv, om, os, bsy);
        if (om !== exp_main) begin $display("FAIL overrun_next got %0d want %0d", om, exp_main); n_fail++; end
        n_cmp++;
        if (ch.overrun !== 1'b1) begin $display("FAIL overrun_sticky got %b want 1", ch.overrun); n_fail++; end
        n_cmp++;
    endtask

    task automatic test_reset_midop();
        int nv = 0, cyc, om, os, bsy;
        do_reset();
        @(negedge clk); ms = 1'b1; tx = 2'sd1;
        @(negedge clk);
        @(negedge clk); ms = 1'b0; reset = 1'b0;
        #1;
        if (ch.busy !== 1'b0 || ch.multi_out !== 14'sd0 || ch.overrun !== 1'b0) begin
            $display("FAIL midop_clear got busy=%b out=%0d ovr=%b want 0 0 0", ch.busy, ch.multi_out, ch.overrun); n_fail++;
        end
        n_cmp++;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            if (ch.multi_valid) nv++;
        end
        reset = 1'b1;
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            if (ch.multi_valid) nv++;
        end
        if (nv !== 0) begin $display("FAIL midop_valid got %0d want 0", nv); n_fail++; end
        n_cmp++;
        syms.delete();
        lfsr_m = 8'hA5;
        send(1, 1'b0, cyc, nv, om, os, bsy);
        if (om !== exp_main || cyc !== 6) begin $display("FAIL midop_next got %0d@%0d want %0d@6", om, cyc, exp_main); n_fail++; end
        n_cmp++;
    endtask

    task automatic test_noise();
        int cyc, nv, om, os, bsy;
        do_reset();
        send(1, 1'b1, cyc, nv, om, os, bsy);
        if (om !== exp_main) begin $display("FAIL noise_on got %0d want %0d", om, exp_main); n_fail++; end
        n_cmp++;
        do_reset();
        send(1, 1'b0, cyc, nv, om, os, bsy);
        if (om !== exp_main) begin $display("FAIL noise_off got %0d want %0d", om, exp_main); n_fail++; end
        n_cmp++;
    endtask

    initial begin
        test_reset();
        test_first_symbol();
        test_stream("alt", 0, 8);
        test_stream("const_pos", 1, 20);
        test_stream("const_neg", 2, 8);
        test_stream("random", 3, 40);
        test_overrun();
        test_reset_midop();
        test_noise();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
